// File: rtl/adventure_pkg.sv
// adventure_pkg: room and move encodings shared with the game, plus the autoplayer state type
package adventure_pkg;
   localparam logic [2:0] ROOM_CAVE   = 3'b000;
   localparam logic [2:0] ROOM_TUNNEL = 3'b001;
   localparam logic [2:0] ROOM_RIVER  = 3'b010;
   localparam logic [2:0] ROOM_SWORD  = 3'b011;
   localparam logic [2:0] ROOM_DRAGON = 3'b100;
   localparam logic [2:0] ROOM_WIN    = 3'b101;
   localparam logic [2:0] ROOM_DIE    = 3'b110;
   localparam logic [1:0] MOVE_N = 2'b00;
   localparam logic [1:0] MOVE_S = 2'b01;
   localparam logic [1:0] MOVE_E = 2'b10;
   localparam logic [1:0] MOVE_W = 2'b11;
   typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE, ST_FAIL} ap_state_t;
endpackage

// File: rtl/move_script_mem.sv
// move_script_mem: append-only route store with combinational read and a length counter
module move_script_mem #(
   parameter int DEPTH = 16,
   localparam int CW = $clog2(DEPTH + 1),
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          load_en,
   input  logic [1:0]    load_dir,
   input  logic [AW-1:0] rd_addr,
   output logic [1:0]    rd_dir,
   output logic [CW-1:0] len
);
   logic [1:0] mem [DEPTH];
   logic wr;
   assign wr = load_en && !clear && len < CW'(DEPTH);
   assign rd_dir = mem[rd_addr];
   always_ff @(posedge clk) begin
      if (!rst_n) len <= '0;
      else if (clear) len <= '0;
      else if (wr) len <= len + CW'(1);
   end
   always_ff @(posedge clk) begin
      if (wr) mem[len[AW-1:0]] <= load_dir;
   end
endmodule

// File: rtl/adventure_autoplayer.sv
// adventure_autoplayer: replays a stored compass route into the game and reports win, death, exhaustion or stall
module adventure_autoplayer
   import adventure_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int TIMEOUT = 8,
   localparam int CW = $clog2(DEPTH + 1),
   localparam int AW = $clog2(DEPTH),
   localparam int TW = $clog2(TIMEOUT)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_en,
   input  logic [1:0]    load_dir,
   input  logic          clear,
   input  logic          start,
   input  logic          abort,
   input  logic [2:0]    room,
   output logic          dir_n,
   output logic          dir_s,
   output logic          dir_e,
   output logic          dir_w,
   output logic          busy,
   output logic          won,
   output logic          failed,
   output logic          timed_out,
   output logic [CW-1:0] moves,
   output logic [CW-1:0] script_len
);
   ap_state_t state, state_d;
   logic [AW-1:0] rd_ptr, rd_ptr_d;
   logic [TW-1:0] timer, timer_d;
   logic [2:0] room_prev, room_prev_d;
   logic [CW-1:0] moves_d, moves_inc;
   logic won_d, failed_d, timed_out_d;
   logic [1:0] cur_dir;
   logic can_start, mem_clear, mem_load, pulse, changed, last;
   move_script_mem #(.DEPTH(DEPTH)) u_mem (
      .clk(clk),
      .rst_n(rst_n),
      .clear(mem_clear),
      .load_en(mem_load),
      .load_dir(load_dir),
      .rd_addr(rd_ptr),
      .rd_dir(cur_dir),
      .len(script_len)
   );
   assign can_start = start && !abort && script_len != '0 && state inside {ST_IDLE, ST_DONE, ST_FAIL};
   // a start that is taken drops any load or clear arriving with it
   assign mem_clear = state == ST_IDLE && clear && !abort && !can_start;
   assign mem_load  = state == ST_IDLE && load_en && !abort && !start;
   assign pulse = state == ST_ISSUE && !abort;
   assign dir_n = pulse && cur_dir == MOVE_N;
   assign dir_s = pulse && cur_dir == MOVE_S;
   assign dir_e = pulse && cur_dir == MOVE_E;
   assign dir_w = pulse && cur_dir == MOVE_W;
   assign busy = state inside {ST_ISSUE, ST_WAIT};
   assign changed = room != room_prev;
   assign last = CW'(rd_ptr) == script_len - CW'(1);
   assign moves_inc = moves == CW'(DEPTH) ? moves : moves + CW'(1);
   always_comb begin
      state_d = state;
      rd_ptr_d = rd_ptr;
      timer_d = timer;
      room_prev_d = room_prev;
      moves_d = moves;
      won_d = won;
      failed_d = failed;
      timed_out_d = timed_out;
      if (abort) begin
         state_d = ST_IDLE;
         won_d = 1'b0;
         failed_d = 1'b0;
         timed_out_d = 1'b0;
      end else if (can_start) begin
         state_d = ST_ISSUE;
         rd_ptr_d = '0;
         moves_d = '0;
         won_d = 1'b0;
         failed_d = 1'b0;
         timed_out_d = 1'b0;
      end else if (state == ST_ISSUE) begin
         room_prev_d = room;
         timer_d = '0;
         state_d = ST_WAIT;
      end else if (state == ST_WAIT) begin
         // progress is checked first so a change on the final timer cycle still counts
         if (changed) begin
            moves_d = moves_inc;
            if (room == ROOM_WIN) begin
               won_d = 1'b1;
               state_d = ST_DONE;
            end else if (room == ROOM_DIE) begin
               failed_d = 1'b1;
               state_d = ST_FAIL;
            end else if (last) begin
               state_d = ST_DONE;
            end else begin
               rd_ptr_d = rd_ptr + AW'(1);
               state_d = ST_ISSUE;
            end
         end else if (timer == TW'(TIMEOUT - 1)) begin
            failed_d = 1'b1;
            timed_out_d = 1'b1;
            state_d = ST_FAIL;
         end else begin
            timer_d = timer + TW'(1);
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         rd_ptr <= '0;
         timer <= '0;
         room_prev <= ROOM_CAVE;
         moves <= '0;
         won <= 1'b0;
         failed <= 1'b0;
         timed_out <= 1'b0;
      end else begin
         state <= state_d;
         rd_ptr <= rd_ptr_d;
         timer <= timer_d;
         room_prev <= room_prev_d;
         moves <= moves_d;
         won <= won_d;
         failed <= failed_d;
         timed_out <= timed_out_d;
      end
   end
endmodule

// File: tb/tb_adventure_autoplayer.sv
// tb_adventure_autoplayer: directed vectors, corner sequences and randomized routes against a game/outcome model
module tb_adventure_autoplayer;
   localparam int DEPTH = 16;
   localparam int TIMEOUT = 8;
   logic clk = 1'b0, rst_n = 1'b0, load_en = 1'b0, clear = 1'b0, start = 1'b0, abort = 1'b0;
   logic [1:0] load_dir = 2'b00;
   logic [2:0] room = 3'b000;
   logic dir_n, dir_s, dir_e, dir_w, busy, won, failed, timed_out;
   logic [4:0] moves, script_len;
   adventure_autoplayer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_dir(load_dir), .clear(clear),
      .start(start), .abort(abort), .room(room), .dir_n(dir_n), .dir_s(dir_s), .dir_e(dir_e),
      .dir_w(dir_w), .busy(busy), .won(won), .failed(failed), .timed_out(timed_out),
      .moves(moves), .script_len(script_len)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic [31:0] scr;
      int n, mode, w, f, t, m, p;
   } vec_t;
   vec_t vt[4];
   int tests = 0, fails = 0;
   int mode = 0, cd = 0, ohv = 0;
   bit sword = 0, armed = 0;
   logic [2:0] pend;
   int dq[$];
   logic [2:0] rq[$];
   logic [1:0] plog[$];
   // game map: S,S from the cave reaches the river; W fetches the sword; E past the dragon wins only when armed
   function automatic logic [2:0] game_next(input logic [2:0] r, input logic [1:0] m, input bit sw);
      case (r)
         3'd0: return m == 2'd1 ? 3'd1 : r;
         3'd1: return m == 2'd1 ? 3'd2 : r;
         3'd2: return m == 2'd3 ? 3'd3 : m == 2'd2 ? 3'd4 : r;
         3'd3: return m == 2'd2 ? 3'd2 : r;
         3'd4: return m == 2'd2 ? (sw ? 3'd5 : 3'd6) : r;
         default: return r;
      endcase
   endfunction
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask
   // one clock: the game reacts to pulses seen on the previous cycle, then new pulses are logged
   task automatic step();
      logic [1:0] c;
      @(negedge clk);
      if (armed) begin
         if (cd == 0) begin
            room = pend;
            armed = 0;
            if (mode == 0 && pend == 3'd3) sword = 1;
         end else cd--;
      end
      if (dir_n | dir_s | dir_e | dir_w) begin
         if ($countones({dir_n, dir_s, dir_e, dir_w}) != 1) ohv++;
         c = dir_s ? 2'd1 : dir_e ? 2'd2 : dir_w ? 2'd3 : 2'd0;
         plog.push_back(c);
         if (mode == 0) begin
            pend = game_next(room, c, sword);
            cd = 0;
            armed = 1;
         end else if (mode == 1 && dq.size() > 0) begin
            cd = dq.pop_front();
            pend = rq.pop_front();
            armed = 1;
         end
      end
   endtask
   task automatic reset_rsp(input int md);
      mode = md;
      room = 3'd0;
      sword = 0;
      armed = 0;
      dq.delete();
      rq.delete();
      plog.delete();
   endtask
   task automatic load_script(input logic [31:0] scr, input int n);
      abort = 1; step(); abort = 0;
      clear = 1; step(); clear = 0;
      for (int i = 0; i < n; i++) begin
         load_en = 1;
         load_dir = scr[2*(i%16) +: 2];
         step();
      end
      load_en = 0;
   endtask
   task automatic run(input string tag);
      start = 1; step(); start = 0;
      for (int i = 0; i < 400 && busy; i++) step();
      check({tag, "_terminates"}, busy, 0);
      for (int i = 0; i < 3; i++) step();
   endtask
   task automatic check_outcome(input string tag, input logic [31:0] scr, input int w, input int f,
                                input int t, input int m, input int p);
      int bad = 0;
      check({tag, "_won"}, won, w);
      check({tag, "_failed"}, failed, f);
      check({tag, "_timed_out"}, timed_out, t);
      check({tag, "_moves"}, moves, m);
      check({tag, "_pulses"}, plog.size(), p);
      for (int i = 0; i < plog.size() && i < 16; i++) if (plog[i] !== scr[2*i +: 2]) bad++;
      check({tag, "_pulse_order"}, bad, 0);
      check({tag, "_onehot"}, ohv, 0);
   endtask
   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   initial begin
      logic [31:0] scr;
      int n, cur, d, w, f, t, m, p;
      logic [2:0] r;
      vt[0] = '{32'h0000_0AB5, 6, 0, 1, 0, 0, 6, 6};
      vt[1] = '{32'h0000_00A5, 4, 0, 0, 1, 0, 4, 4};
      vt[2] = '{32'h0000_0001, 1, 2, 0, 1, 1, 0, 1};
      vt[3] = '{32'h0000_0001, 1, 0, 0, 0, 0, 1, 1};
      rst_n = 0; step(); step();
      check("reset_flags", {dir_n, dir_s, dir_e, dir_w, busy, won, failed, timed_out}, 0);
      check("reset_moves", moves, 0);
      check("reset_len", script_len, 0);
      rst_n = 1; step();
      for (int k = 0; k < 4; k++) begin
         reset_rsp(vt[k].mode);
         load_script(vt[k].scr, vt[k].n);
         check($sformatf("vec%0d_len", k), script_len, vt[k].n);
         run($sformatf("vec%0d", k));
         check_outcome($sformatf("vec%0d", k), vt[k].scr, vt[k].w, vt[k].f, vt[k].t, vt[k].m, vt[k].p);
      end
      reset_rsp(2);
      load_script(32'h1, 1);
      start = 1; step(); start = 0;
      check("stall_pulse", {dir_n, dir_s, dir_e, dir_w}, 4'b0100);
      for (int k = 1; k <= TIMEOUT; k++) step();
      check("stall_not_yet", failed, 0);
      step();
      check("stall_failed", {failed, timed_out, busy}, 3'b110);
      check("stall_pulses", plog.size(), 1);
      check("stall_moves", moves, 0);
      reset_rsp(2);
      load_script($urandom, 17);
      check("load_full", script_len, 16);
      clear = 1; load_en = 1; step(); clear = 0; load_en = 0;
      check("clear_beats_load", script_len, 0);
      start = 1; step(); start = 0;
      check("start_empty_busy", busy, 0);
      step();
      check("start_empty_pulses", plog.size(), 0);
      reset_rsp(0);
      load_script(32'h0000_0AB5, 6);
      start = 1; step(); start = 0;
      for (int i = 0; i < 100 && moves != 2; i++) step();
      check("abort_reach_m2", moves, 2);
      step();
      abort = 1; #1;
      check("abort_wait_dirs", {dir_n, dir_s, dir_e, dir_w}, 0);
      step(); abort = 0;
      check("abort_idle", {busy, won, failed, timed_out}, 0);
      check("abort_moves", moves, 2);
      check("abort_len", script_len, 6);
      reset_rsp(0);
      start = 1; step(); start = 0;
      abort = 1; #1;
      check("abort_issue_dirs", {dir_n, dir_s, dir_e, dir_w}, 0);
      step(); abort = 0;
      check("abort_issue_busy", busy, 0);
      reset_rsp(0);
      start = 1; step(); start = 0; step(); step();
      rst_n = 0; step();
      check("midreset_flags", {dir_n, dir_s, dir_e, dir_w, busy, won, failed, timed_out}, 0);
      check("midreset_moves", moves, 0);
      check("midreset_len", script_len, 0);
      rst_n = 1; step();
      for (int it = 0; it < 30; it++) begin
         reset_rsp(1);
         scr = $urandom;
         n = $urandom_range(1, 16);
         load_script(scr, n);
         cur = 0; w = 0; f = 0; t = 0; m = n; p = n;
         for (int i = 0; i < n; i++) begin
            d = ($urandom % 4 == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT) : $urandom_range(0, 3);
            r = 3'((cur + 1 + int'($urandom % 6)) % 7);
            dq.push_back(d);
            rq.push_back(r);
            if (d >= TIMEOUT) begin
               f = 1; t = 1; m = i; p = i + 1;
               break;
            end
            cur = int'(r);
            if (r == 3'd5 || r == 3'd6) begin
               w = (r == 3'd5); f = (r == 3'd6); m = i + 1; p = i + 1;
               break;
            end
         end
         run($sformatf("rnd%0d", it));
         check_outcome($sformatf("rnd%0d", it), scr, w, f, t, m, p);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
